// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 command master: FSM encoding and PPROT bit positions.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int PROT_PRIV   = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR  = 2;

endpackage

// File: rtl/apb4_cmd_master.sv
// APB4 requester: turns one valid/ready command into one APB4 transfer and returns
// the outcome on a valid/ready response port, with an optional PREADY timeout.
module apb4_cmd_master
  import apb4_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DS      = DW / 8,
  parameter int TIMEOUT = 0
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [DS-1:0] cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  output logic [DS-1:0] PSTRB,
  output logic [2:0]    PPROT,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam bit            TO_EN = (TIMEOUT > 0);
  localparam int            CW    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          complete;
  logic          abort;

  // The transfer is abandoned on the edge where this wait cycle would bring the count to TIMEOUT.
  assign timeout_hit = TO_EN && (wait_cnt == LIMIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE:   if (cmd_valid) state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          state_nx = RESP;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:   if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (TO_EN && state == ACCESS && !PREADY && wait_cnt != SAT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Handshake and APB control flops are decoded from the next state so they change with it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
    end else begin
      cmd_ready <= (state_nx == IDLE);
      rsp_valid <= (state_nx == RESP);
      PSEL      <= (state_nx == SETUP) || (state_nx == ACCESS);
      PENABLE   <= (state_nx == ACCESS);

      if (state == IDLE && cmd_valid) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb : '0;
        PPROT  <= cmd_prot;
      end

      if (complete) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: a memory-like APB4 completer with programmable
// wait states, errors and hangs, plus a word-array reference model of expected responses.
module tb_apb4_cmd_master;
  import apb4_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DS = 4;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DS-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DS-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  always #5 PCLK = ~PCLK;

  apb4_cmd_master #(.AW(AW), .DW(DW), .DS(DS), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Completer: 16-word memory, ready after c_waits low cycles, garbage whenever not ready.
  logic [31:0] mem [16] = '{default: 32'h0};
  int          acc;
  int          c_waits = 0;
  logic        c_err = 1'b0, c_stuck = 1'b0, c_ovr_en = 1'b0;
  logic [31:0] c_ovr = '0;
  logic [31:0] junk = 32'h1357_9bdf;
  logic        junk_b = 1'b1;

  always @(posedge PCLK) begin
    junk   <= $urandom;
    junk_b <= 1'($urandom);
  end

  assign PREADY  = PSEL && PENABLE && !c_stuck && (acc >= c_waits);
  assign PRDATA  = (PREADY && !PWRITE) ? (c_ovr_en ? c_ovr : mem[PADDR[5:2]]) : junk;
  assign PSLVERR = PREADY ? c_err : junk_b;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                      acc <= 0;
    else if (PSEL && PENABLE && !PREADY) acc <= acc + 1;
    else                               acc <= 0;
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  // Reference model: what each word should hold after the commands issued so far.
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic err, input logic stuck, input logic ovr_en,
                      input logic [31:0] ovr, input int rsp_delay);
    logic [31:0] exp_rdata, exp_pw, mask;
    logic [3:0]  exp_ps;
    logic        exp_err, exp_to, bad, got;
    int          exp_acc, setup_n, acc_n, k;
    logic [31:0] r_rdata;
    logic        r_err, r_to;

    exp_pw  = wr ? wdata : 32'h0;
    exp_ps  = wr ? strb : 4'h0;
    exp_acc = stuck ? TO : waits + 1;
    exp_err = stuck | err;
    exp_to  = stuck;
    if (stuck || wr)  exp_rdata = 32'h0;
    else if (ovr_en)  exp_rdata = ovr;
    else              exp_rdata = ref_mem[addr[5:2]];
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (wr && !err && !stuck)
      ref_mem[addr[5:2]] = (ref_mem[addr[5:2]] & ~mask) | (wdata & mask);

    c_waits = waits; c_err = err; c_stuck = stuck; c_ovr_en = ovr_en; c_ovr = ovr;

    @(negedge PCLK);
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    cmd_prot = 3'($urandom); cmd_write = 1'($urandom);

    setup_n = 0; acc_n = 0; bad = 1'b0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (PSEL && !PENABLE) setup_n++;
      if (PSEL && PENABLE) begin
        if (setup_n == 0) bad = 1'b1;
        acc_n++;
      end
      if (!PSEL || cmd_ready || PADDR !== addr || PWRITE !== wr || PWDATA !== exp_pw ||
          PSTRB !== exp_ps || PPROT !== prot) bad = 1'b1;
    end
    check("rsp_arrives", 64'(got), 64'd1);
    check("setup_cycles", 64'(setup_n), 64'd1);
    check("access_cycles", 64'(acc_n), 64'(exp_acc));
    check("apb_hold", 64'(bad), 64'd0);
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    check("psel_low_in_resp", 64'({PSEL, PENABLE, cmd_ready}), 64'd0);

    r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
    bad = 1'b0;
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge PCLK);
      if (!rsp_valid || rsp_rdata !== r_rdata || rsp_err !== r_err || rsp_timeout !== r_to ||
          cmd_ready || PSEL) bad = 1'b1;
    end
    check("rsp_backpressure", 64'(bad), 64'd0);

    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("paddr_hold_idle", 64'(PADDR), 64'(addr));
  endtask

  task automatic reset_mid_access();
    logic bad;
    c_waits = 0; c_err = 1'b0; c_stuck = 1'b1; c_ovr_en = 1'b0;
    @(negedge PCLK);
    cmd_addr = 32'h24; cmd_write = 1'b1; cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF;
    cmd_prot = 3'b0; cmd_valid = 1'b1;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("mid_in_access", 64'({PSEL, PENABLE}), 64'd3);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    c_stuck = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rsp_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL || !cmd_ready) bad = 1'b1;
    end
    rsp_ready = 1'b0;
    check("no_rsp_after_reset", 64'(bad), 64'd0);
  endtask

  initial begin
    logic        wr, err, stuck;
    logic [31:0] a;

    #12;
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_ctrl", 64'({PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    check("reset_data", 64'(PADDR | PWDATA | rsp_rdata), 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Full write, then read back with junk strobes/data that must not reach the bus.
    xfer(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'(1 << PROT_PRIV), 0, 0, 0, 0, 0, 0);
    xfer(1'b0, 32'h10, 32'hFFFF_0000, 4'hF, 3'(1 << PROT_NONSEC), 0, 0, 0, 0, 0, 0);
    // Partial write onto a zero word.
    xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0101, 3'b0, 0, 0, 0, 0, 0, 0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b0, 0, 0, 0, 0, 0, 0);
    // Three wait states, ready on the last cycle before the timeout would fire.
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'(1 << PROT_INSTR), 3, 0, 0, 1, 32'hDEAD_BEEF, 0);
    // Slave error with a stalled response consumer.
    xfer(1'b1, 32'h30, 32'h5555_AAAA, 4'hF, 3'b0, 1, 1, 0, 0, 0, 5);
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b0, 0, 1, 0, 0, 0, 2);
    // Hung completer hits the timeout.
    xfer(1'b0, 32'h14, 32'h0, 4'h0, 3'b0, 0, 0, 1, 0, 0, 1);
    xfer(1'b1, 32'h18, 32'h0BAD_0BAD, 4'hF, 3'b0, 0, 0, 1, 0, 0, 0);

    reset_mid_access();

    for (int n = 0; n < 24; n++) begin
      wr    = 1'($urandom);
      err   = ($urandom_range(0, 4) == 0);
      stuck = ($urandom_range(0, 7) == 0);
      a     = $urandom;
      xfer(wr, a, $urandom, 4'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
           err, stuck, 1'b0, 32'h0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/apb4_cmd_master.md
Name: apb4_cmd_master

Overview:
- APB4 initiator (requester) driving one APB4 completer, e.g. the team's APB4 memory, from a simple valid/ready command port.
- One transfer at a time: command accepted → SETUP → ACCESS (wait states via PREADY) → response returned on a valid/ready response port.
- Optional PREADY timeout aborts hung transfers.
- Sits behind bus bridges and test stimulus generators.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- DS, DW/8, number of byte strobes.
- TIMEOUT, 0, ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PRESETn  in  1  asynchronous active-low reset
- PCLK  in  1  single clock; all logic on rising edge
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  AW  transfer address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DW  write data
- cmd_strb  in  DS  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DW  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  AW  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PSTRB  out  DS  APB strobes
- PPROT  out  3  APB protection
- PRDATA  in  DW  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset values: all outputs are registered and reset to 0, except cmd_ready, which is 1.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid, latch the command into the APB outputs and go to SETUP.
  - Reads drive PSTRB=0 and PWDATA=0, regardless of cmd_strb/cmd_wdata.
- SETUP (exactly one cycle):
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Always go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable from SETUP until the transfer ends.
  - At a rising edge with PREADY=1:
    - capture rsp_rdata = PWRITE ? 0 : PRDATA;
    - capture rsp_err = PSLVERR and rsp_timeout = 0;
    - drop PSEL and PENABLE; go to RESP.
  - PRDATA and PSLVERR are ignored while PREADY=0.
- Wait counter (TIMEOUT>0 only):
  - Cleared on entry to ACCESS; increments on each ACCESS cycle with PREADY=0.
  - If the counter reaches TIMEOUT while PREADY is still 0: capture rsp_err=1, rsp_timeout=1, rsp_rdata=0; drop PSEL/PENABLE; go to RESP.
  - PREADY=1 on the same edge the counter would expire takes priority: normal completion.
  - Counter width is clog2(TIMEOUT+1); saturates and never wraps.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE, cmd_ready=1 next cycle.
  - cmd_ready=0 throughout RESP, so a command presented during RESP waits.
- Latency:
  - Command accepted at edge N → SETUP during N..N+1 → ACCESS from N+1.
  - With zero wait states, rsp_valid=1 after edge N+2.
  - Each wait state adds one cycle.
  - Minimum command-to-command spacing is 4 cycles with rsp_ready tied high.
- PADDR/PWRITE/PPROT/PWDATA/PSTRB hold their last values in IDLE and RESP; only PSEL and PENABLE return low.
- Reset asserted mid-transfer:
  - All outputs return asynchronously to their reset values.
  - The in-flight transfer is dropped; no response is produced.
  - After release, FSM is in IDLE.
- No address alignment checks; PADDR is driven exactly as cmd_addr.

Decomposition:
- Package apb4_pkg holds:
  - state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3;
  - PPROT bit constants: PRIV=bit0, NONSEC=bit1, INSTR=bit2.
- Single module; no sub-module.
- The timeout counter is inline.

Test Plan:
- Write, zero wait states: cmd addr=0x10, wdata=0xA5A5_1234, strb=4'hF; APB4 memory completer.
  - PSEL high 2 cycles, PENABLE high in cycle 2 only; rsp_valid 3 cycles after acceptance; rsp_err=0, rsp_rdata=0.
  - Read of 0x10 returns 0xA5A5_1234 with PSTRB=0 during the read.
- Partial write: strb=4'b0101, wdata=0xFFFF_FFFF onto 0x0000_0000 → read-back 0x00FF_00FF.
- Wait states: completer holds PREADY low 3 ACCESS cycles, then returns PRDATA=0xDEAD_BEEF.
  - PADDR/PWRITE stable throughout; response 3 cycles later than zero-wait; rsp_rdata=0xDEAD_BEEF.
- Error and backpressure: PSLVERR=1 with PREADY → rsp_err=1, rsp_timeout=0.
  - rsp_ready held low 5 cycles → rsp_* stable, cmd_ready=0.
- Timeout: TIMEOUT=4, PREADY stuck low → PSEL drops after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - With PREADY=1 on the 4th cycle → normal completion.
- Reset mid-ACCESS: PRESETn low during a wait state → PSEL, PENABLE and rsp_valid go low immediately, cmd_ready=1 after release, no response ever issued.
